multu_unit: RTL and testbench
=============================

Name: multu_unit

Overview:
- Sequential unsigned 32x32 multiplier and HI/LO register file for the midterm datapath.
- Responds to the MULTU enable produced by the ALU control decode. Executes a 32-iteration shift-add multiply and holds the 64-bit product in HI/LO.
- Returns HI or LO onto the result path when the function field selects MFHI or MFLO.
- Sits beside the ALU and shifter; its read output feeds the result-select mux.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- MFHI, 6'b010000, function code selecting HI on dataOut.
- MFLO, 6'b010010, function code selecting LO on dataOut.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- dataA  input  WIDTH  multiplicand (rs).
- dataB  input  WIDTH  multiplier (rt).
- SignaltoMULTU  input  1  start request from ALU control decode.
- Signal  input  6  function field; selects the HI/LO read.
- dataOut  output  WIDTH  HI, LO or zero per Signal.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse when HI/LO have been updated.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset (sampled on a clk edge):
  - state=IDLE; HI=0, LO=0; busy=0, done=0.
  - Internal multiplicand, multiplier, product and counter cleared.
  - Reset overrides a simultaneous start.
  - Reset mid-operation aborts the multiply; HI/LO go to 0, not a partial product.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with SignaltoMULTU=1: mcand (2*WIDTH) = {0, dataA}; mplier = dataB; prod = 0; cnt = 0; go to RUN.
  - Operands are latched only at this edge; later changes on dataA/dataB have no effect.
- RUN, each edge:
  - If mplier[0], prod = prod + mcand (2*WIDTH, no overflow possible).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - On the 32nd iteration (cnt==31 before increment): HI = final prod[63:32], LO = prod[31:0], including that edge's add; go to DONE.
- DONE:
  - done=1 for exactly this one cycle; go to IDLE on the next edge.
  - A start sampled during DONE is accepted and behaves as from IDLE (back-to-back multiplies).
- busy:
  - busy=1 while state==RUN. Start at edge N gives busy high after edges N+1..N+32 inclusive of the cycle following edge N.
  - Precisely: busy rises after edge N, HI/LO update at edge N+32, done is high in the cycle after edge N+32, busy is low in that same cycle.
- Latency: 32 cycles from start edge to HI/LO update.
- Start asserted while in RUN is ignored; no queueing, operands not relatched.
- Read path (combinational from registered HI/LO):
  - dataOut = HI if Signal==MFHI.
  - dataOut = LO if Signal==MFLO.
  - Otherwise dataOut = 0.
- A read during RUN returns the previous HI/LO values; stalling is the hazard unit's responsibility.
- In the DONE cycle, reads return the new values.
- No signed handling; operands are treated as unsigned.

Test Plan:
- Reset, then Signal=MFHI and then MFLO -> dataOut=0 both times; busy=0, done=0.
- dataA=3, dataB=5, start 1 cycle -> busy for 32 cycles, done pulses once at cycle 33; MFHI->0x00000000, MFLO->0x0000000F.
- dataA=0xFFFFFFFF, dataB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- dataA=0x80000000, dataB=2; at cycle 5 change dataA to 7 and re-pulse start -> start ignored; result HI=0x00000001, LO=0x00000000; MFLO read during RUN returns the prior LO.
- Start 0x1234*0x10, assert reset at cycle 10 -> next cycle state IDLE, busy=0, HI=LO=0, no done pulse.
- Back-to-back: start 2*3, then start 4*5 in the done cycle -> first done gives LO=6; second done 33 cycles later gives LO=20, HI=0.

Source files
------------

// File: rtl/multu_unit.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier with HI/LO product registers.
// HI/LO are read combinationally onto dataOut when Signal selects MFHI or MFLO.
module multu_unit #(
  parameter int unsigned WIDTH = 32,
  parameter logic [5:0]  MFHI  = 6'b010000,
  parameter logic [5:0]  MFLO  = 6'b010010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             SignaltoMULTU,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prodSum;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic             lastIter;
  logic             loadOp;

  // Iteration arithmetic; the final add feeds HI/LO directly on the last edge.
  always_comb begin
    prodSum  = mplier[0] ? (prod + mcand) : prod;
    lastIter = (cnt == CW'(WIDTH - 1));
    loadOp   = ((state == IDLE) || (state == DONE)) && SignaltoMULTU;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (SignaltoMULTU) nextState = RUN;
      RUN:     if (lastIter) nextState = DONE;
      DONE:    nextState = SignaltoMULTU ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath and registered status flags follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (nextState == RUN);
      done <= (nextState == DONE);
      if (loadOp) begin
        mcand  <= PW'(dataA);
        mplier <= dataB;
        prod   <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        prod   <= prodSum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (lastIter) begin
          hi <= prodSum[PW-1:WIDTH];
          lo <= prodSum[WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    dataOut = '0;
    if (Signal == MFHI)      dataOut = hi;
    else if (Signal == MFLO) dataOut = lo;
  end

endmodule

// File: tb/tb_multu_unit.sv
// Randomized self-checking bench for multu_unit against a plain-arithmetic product model.
module tb_multu_unit;

  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        SignaltoMULTU;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int unsigned checkCnt;
  int unsigned passCnt;
  logic [31:0] modelHi;
  logic [31:0] modelLo;

  multu_unit dut (
    .clk           (clk),
    .reset         (reset),
    .dataA         (dataA),
    .dataB         (dataB),
    .SignaltoMULTU (SignaltoMULTU),
    .Signal        (Signal),
    .dataOut       (dataOut),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [5:0] fn, output logic [31:0] val);
    Signal = fn;
    #1;
    val = dataOut;
  endtask

  task automatic checkRegs(input string tag);
    logic [31:0] v;
    readReg(MFHI, v);
    checkVal({tag, " hi"}, 64'(v), 64'(modelHi));
    readReg(MFLO, v);
    checkVal({tag, " lo"}, 64'(v), 64'(modelLo));
  endtask

  // Drive one start edge with the given operands.
  task automatic startOp(input logic [31:0] a, input logic [31:0] b);
    dataA = a;
    dataB = b;
    SignaltoMULTU = 1'b1;
    tick();
    SignaltoMULTU = 1'b0;
  endtask

  // Walk the 32 busy cycles, then check the done cycle against the model.
  // retryAt > 0 re-pulses start with a changed dataA at that busy cycle.
  task automatic waitDone(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int retryAt);
    logic [63:0] full;
    logic [31:0] v;
    full = 64'(a) * 64'(b);
    for (int k = 1; k <= 32; k++) begin
      checkVal({tag, " busy"}, 64'(busy), 64'd1);
      checkVal({tag, " done early"}, 64'(done), 64'd0);
      if (k == 3) begin
        readReg(MFLO, v);
        checkVal({tag, " lo during run"}, 64'(v), 64'(modelLo));
      end
      if (k == retryAt) begin
        dataA = 32'd7;
        SignaltoMULTU = 1'b1;
        tick();
        SignaltoMULTU = 1'b0;
      end else begin
        tick();
      end
    end
    modelHi = full[63:32];
    modelLo = full[31:0];
    checkVal({tag, " done"}, 64'(done), 64'd1);
    checkVal({tag, " busy at done"}, 64'(busy), 64'd0);
    checkRegs(tag);
  endtask

  task automatic idleAfter(input string tag);
    tick();
    checkVal({tag, " done drop"}, 64'(done), 64'd0);
    checkVal({tag, " busy idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] ra;
    logic [31:0] rb;
    checkCnt = 0;
    passCnt = 0;
    modelHi = '0;
    modelLo = '0;
    reset = 1'b1;
    dataA = '0;
    dataB = '0;
    SignaltoMULTU = 1'b1;
    Signal = '0;
    tick();
    tick();
    SignaltoMULTU = 1'b0;
    reset = 1'b0;
    checkRegs("reset");
    checkVal("reset busy", 64'(busy), 64'd0);
    checkVal("reset done", 64'(done), 64'd0);
    tick();
    checkVal("reset ignores start", 64'(busy), 64'd0);

    startOp(32'd3, 32'd5);
    waitDone("3x5", 32'd3, 32'd5, 0);
    idleAfter("3x5");

    startOp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    readReg(6'b100000, v);
    checkVal("other fn zero", 64'(v), 64'd0);
    idleAfter("max");

    startOp(32'h8000_0000, 32'd2);
    waitDone("ignore restart", 32'h8000_0000, 32'd2, 5);
    idleAfter("ignore restart");

    // Abort mid-run: registers clear and no done pulse follows.
    startOp(32'h1234, 32'h10);
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelHi = '0;
    modelLo = '0;
    checkVal("abort busy", 64'(busy), 64'd0);
    checkVal("abort done", 64'(done), 64'd0);
    checkRegs("abort");
    for (int k = 0; k < 30; k++) begin
      if (done !== 1'b0) checkVal("abort late done", 64'(done), 64'd0);
      tick();
    end
    checkVal("abort quiet", 64'(busy), 64'd0);

    startOp(32'd2, 32'd3);
    waitDone("b2b first", 32'd2, 32'd3, 0);
    startOp(32'd4, 32'd5);
    waitDone("b2b second", 32'd4, 32'd5, 0);
    idleAfter("b2b");

    for (int n = 0; n < 8; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n == 0) ra = '0;
      if (n == 1) rb = 32'd1;
      startOp(ra, rb);
      waitDone($sformatf("rand%0d", n), ra, rb, 0);
      if (n % 2 == 0) idleAfter($sformatf("rand%0d", n));
    end
    idleAfter("final");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
